// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and defaults for the instruction fetch queue.
// Holds the fetch FSM state encoding, default geometry (DEPTH, PC_W),
// the instruction word width and a saturating counter helper.
package ifq_pkg;

  localparam int unsigned IFQ_DEPTH  = 4;
  localparam int unsigned IFQ_PC_W   = 9;
  localparam int unsigned IFQ_INST_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifq_state_e;

  // Increment a 16-bit event counter, sticking at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ifq_fetch_if.sv
// ifq_fetch_if: instruction memory read port plus the decode-side
// valid/ready handshake of the fetch queue. The master modport is the
// fetch unit; the slave modport is the memory/decode environment.
interface ifq_fetch_if
  import ifq_pkg::*;
#(
  parameter int unsigned PC_W = IFQ_PC_W
);

  logic [PC_W-1:0]       imem_addr;
  logic [IFQ_INST_W-1:0] imem_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [IFQ_INST_W-1:0] inst_data;
  logic [PC_W-1:0]       inst_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc
  );

endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo: circular buffer of {instruction, pc} entries with occupancy
// count. A pop on a full queue frees the slot for a same-cycle push.
// clear empties the queue; reset also zeroes the storage so the head
// outputs read as zero straight after reset.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned PC_W  = IFQ_PC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic                        i_clear,
  input  logic [IFQ_INST_W-1:0]       i_wr_data,
  input  logic [PC_W-1:0]             i_wr_pc,
  output logic [IFQ_INST_W-1:0]       o_rd_data,
  output logic [PC_W-1:0]             o_rd_pc,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [IFQ_INST_W-1:0] r_mem_data [DEPTH];
  logic [PC_W-1:0]       r_mem_pc   [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Storage, pointer and occupancy update; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_data[i] <= {IFQ_INST_W{1'b0}};
        r_mem_pc[i]   <= {PC_W{1'b0}};
      end
    end else if (i_clear) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_mem_data[r_wr_ptr] <= i_wr_data;
        r_mem_pc[r_wr_ptr]   <= i_wr_pc;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem_data[r_rd_ptr];
  assign o_rd_pc   = r_mem_pc[r_rd_ptr];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/ifq_fetch.sv
// ifq_fetch: sequential instruction fetcher feeding a small queue.
// The pc register addresses instruction memory directly; while RUN the
// word read back is pushed with its pc every cycle the queue has room.
// flush redirects the pc and empties the queue in any state.
// Optional build macro IFQ_FETCH_PERF_EN adds stall/bubble counters
// (o_stall_cnt, o_bubble_cnt); without it those ports do not exist.
module ifq_fetch
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned PC_W  = IFQ_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_flush,
  input  logic [PC_W-1:0] i_flush_pc,
  output logic            o_busy,
`ifdef IFQ_FETCH_PERF_EN
  output logic [15:0]     o_stall_cnt,
  output logic [15:0]     o_bubble_cnt,
`endif
  ifq_fetch_if.master     bus
);

  ifq_state_e      r_state;
  logic            r_busy;
  logic [PC_W-1:0] r_pc;

  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [IFQ_INST_W-1:0]  w_rd_data;
  logic [PC_W-1:0]        w_rd_pc;
  logic                   w_valid;
  logic                   w_handshake;
  logic                   w_pop;
  logic                   w_push;

  assign w_valid     = (w_count != '0);
  assign w_handshake = w_valid && bus.inst_ready;
  // A flush cycle discards the queue, so any handshake that cycle is void.
  assign w_pop       = w_handshake && !i_flush;
  assign w_push      = (r_state == RUN) && !i_flush && (!w_full || w_pop);

  ifq_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_clear   (i_flush),
    .i_wr_data (bus.imem_data),
    .i_wr_pc   (r_pc),
    .o_rd_data (w_rd_data),
    .o_rd_pc   (w_rd_pc),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Fetch control FSM with registered busy flag, plus the pc register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_pc    <= {PC_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          if (i_stop) begin
            r_state <= DRAIN;
          end else begin
            r_state <= RUN;
          end
          r_busy <= 1'b1;
        end
        DRAIN: begin
          // Leave once the queue has emptied; a flush empties it at once.
          if (i_flush || w_empty) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= DRAIN;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // pc wraps naturally at 2^PC_W.
      if (i_flush) begin
        r_pc <= i_flush_pc;
      end else if (w_push) begin
        r_pc <= r_pc + PC_W'(1);
      end else begin
        r_pc <= r_pc;
      end
    end
  end

`ifdef IFQ_FETCH_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  // Saturating stall (full, no drain) and bubble (busy, nothing to offer) counters.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_stall_cnt  <= 16'd0;
      r_bubble_cnt <= 16'd0;
    end else begin
      if ((r_state == RUN) && w_full && !w_handshake) begin
        r_stall_cnt <= sat_inc16(r_stall_cnt);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (r_busy && !w_valid && bus.inst_ready) begin
        r_bubble_cnt <= sat_inc16(r_bubble_cnt);
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst_data  = w_rd_data;
  assign bus.inst_pc    = w_rd_pc;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_ifq_fetch.sv
// tb_ifq_fetch: directed bench for ifq_fetch (DEPTH=4, PC_W=9).
// Memory model returns 0x20000000 + address. Expected head entries are
// queued when fetching is started and popped as the DUT presents them.
module tb_ifq_fetch;

  localparam int PC_W  = 9;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            stop;
  logic            flush;
  logic [PC_W-1:0] flush_pc;
  logic            busy;
`ifdef IFQ_FETCH_PERF_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [PC_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  ifq_fetch_if #(.PC_W(PC_W)) bus ();

  assign bus.imem_data = 32'h2000_0000 + {23'd0, bus.imem_addr};

  ifq_fetch #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_stop       (stop),
    .i_flush      (flush),
    .i_flush_pc   (flush_pc),
    .o_busy       (busy),
`ifdef IFQ_FETCH_PERF_EN
    .o_stall_cnt  (stall_cnt),
    .o_bubble_cnt (bubble_cnt),
`endif
    .bus          (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag);
    logic [PC_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed_pc=0x%0h expected=scoreboard_entry", tag, bus.inst_pc);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(bus.inst_valid), 64'd1);
      chk({tag, "_pc"},    64'(bus.inst_pc),    64'(e));
      chk({tag, "_data"},  64'(bus.inst_data),  64'(32'h2000_0000 + {23'd0, e}));
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    flush          = 1'b0;
    flush_pc       = '0;
    bus.inst_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_data",  64'(bus.inst_data),  64'd0);
    chk("rst_pc",    64'(bus.inst_pc),    64'd0);
    chk("rst_busy",  64'(busy),           64'd0);
    chk("rst_addr",  64'(bus.imem_addr),  64'd0);

    // Streaming with ready held high: one instruction per cycle
    bus.inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_busy",   64'(busy),           64'd1);
    chk("a_empty0", 64'(bus.inst_valid), 64'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(PC_W'(i));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_head("a_stream");
    end
    chk("a_addr", 64'(bus.imem_addr), 64'd8);
`ifdef IFQ_FETCH_PERF_EN
    chk("a_bubble", 64'(bubble_cnt), 64'd1);
`endif

    // Backpressure: queue fills, head stays stable, then drains in order
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("b_hold_valid", 64'(bus.inst_valid), 64'd1);
      chk("b_hold_pc",    64'(bus.inst_pc),    64'd0);
      chk("b_hold_data",  64'(bus.inst_data),  64'h2000_0000);
    end
    chk("b_pc_stop", 64'(bus.imem_addr), 64'd4);
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(PC_W'(i));
    for (int i = 0; i < 8; i++) begin
      chk_head("b_drain");
      tick();
    end

    // Flush with three entries queued
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("c_pre_addr", 64'(bus.imem_addr), 64'd3);
    flush    = 1'b1;
    flush_pc = 9'h100;
    tick();
    flush = 1'b0;
    chk("c_flush_valid", 64'(bus.inst_valid), 64'd0);
    chk("c_flush_addr",  64'(bus.imem_addr),  64'h100);
    tick();
    exp_q.push_back(9'h100);
    chk_head("c_redirect");

    // pc wrap at the top of the address space
    do_reset();
    flush    = 1'b1;
    flush_pc = 9'h1FE;
    tick();
    flush = 1'b0;
    chk("d_addr", 64'(bus.imem_addr), 64'h1FE);
    chk("d_idle", 64'(busy),          64'd0);
    bus.inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(9'h1FE);
    exp_q.push_back(9'h1FF);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_head("d_wrap");
    end

    // Stop with two entries queued, then drain to idle
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("e_busy",  64'(busy),          64'd1);
    chk("e_addr",  64'(bus.imem_addr), 64'd2);
    bus.inst_ready = 1'b1;
    exp_q.push_back(9'd0);
    exp_q.push_back(9'd1);
    chk_head("e_drain");
    tick();
    chk_head("e_drain");
    tick();
    chk("e_empty", 64'(bus.inst_valid), 64'd0);
    tick();
    chk("e_idle",    64'(busy),           64'd0);
    chk("e_nofetch", 64'(bus.imem_addr),  64'd2);
    tick();
    chk("e_still_addr",  64'(bus.imem_addr),  64'd2);
    chk("e_still_empty", 64'(bus.inst_valid), 64'd0);

    // Reset in the middle of RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_valid", 64'(bus.inst_valid), 64'd0);
    chk("r_data",  64'(bus.inst_data),  64'd0);
    chk("r_pc",    64'(bus.inst_pc),    64'd0);
    chk("r_busy",  64'(busy),           64'd0);
    chk("r_addr",  64'(bus.imem_addr),  64'd0);

    // Flush and stop together in RUN
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    flush    = 1'b1;
    flush_pc = 9'h055;
    stop     = 1'b1;
    tick();
    flush = 1'b0;
    stop  = 1'b0;
    chk("f_busy",  64'(busy),           64'd1);
    chk("f_valid", 64'(bus.inst_valid), 64'd0);
    chk("f_addr",  64'(bus.imem_addr),  64'h055);
    tick();
    chk("f_idle",  64'(busy),           64'd0);
    chk("f_addr2", 64'(bus.imem_addr),  64'h055);

`ifdef IFQ_FETCH_PERF_EN
    // Stall counting while full, cleared by flush
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("g_stall0", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("g_stall20", 64'(stall_cnt), 64'd20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("g_stall_clr", 64'(stall_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
